bram_capture_sequencer: RTL and testbench

Sequences the bramController capture buffer. Turns record, play and stop requests into beginWrite/beginRead pulses and waits on the writeComplete/readReady handshakes. On playback it walks readAddress over the whole buffer and presents each returned word on a valid-qualified output, with a watchdog on every handshake wait.

---
 rtl/bram_capture_sequencer_if.sv | 32 +++
 rtl/bram_capture_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_bram_capture_sequencer.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_capture_sequencer_if.sv
// bram_capture_sequencer_if: handshake bundle between the capture sequencer
// and bramController (write/read start strobes, read address, completions, data).
interface bram_capture_sequencer_if #(
    parameter int unsigned WORD_WIDTH = 24,
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  beginWrite;
    logic                  beginRead;
    logic [ADDR_WIDTH-1:0] readAddress;
    logic                  writeComplete;
    logic                  readReady;
    logic [WORD_WIDTH-1:0] outData;

    // Sequencer side drives the strobes and address, controller answers.
    modport master (
        output beginWrite,
        output beginRead,
        output readAddress,
        input  writeComplete,
        input  readReady,
        input  outData
    );

    modport slave (
        input  beginWrite,
        input  beginRead,
        input  readAddress,
        output writeComplete,
        output readReady,
        output outData
    );
endinterface

// File: rtl/bram_capture_sequencer.sv
// bram_capture_sequencer: turns record/play/stop requests into bramController
// beginWrite/beginRead strobes, walks readAddress over the buffer on playback
// and guards every handshake wait with a watchdog.
// Optional build macro LOOP_PLAYBACK_EN: playback wraps at the last address and
// streams until stopReq; undefined gives a single pass over the buffer.
module bram_capture_sequencer #(
    parameter int unsigned WORD_WIDTH     = 24,
    parameter int unsigned ADDR_WIDTH     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    bram_capture_sequencer_if.master bram,
    input  logic                     recReq,
    input  logic                     playReq,
    input  logic                     stopReq,
    output logic [WORD_WIDTH-1:0]    playData,
    output logic                     playValid,
    output logic                     busy,
    output logic                     bufferValid,
    output logic                     timeoutErr
);

    // Counter only needs to hold TIMEOUT_CYCLES-1; expiry fires on the cycle it would reach the limit.
    localparam int unsigned WD_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_WIDTH-1:0]   WD_LAST   = WD_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WR_START = 3'd1;
    localparam logic [2:0] WR_WAIT  = 3'd2;
    localparam logic [2:0] RD_SETUP = 3'd3;
    localparam logic [2:0] RD_START = 3'd4;
    localparam logic [2:0] RD_WAIT  = 3'd5;
    localparam logic [2:0] RD_NEXT  = 3'd6;

    logic [2:0]            state;
    logic [2:0]            stateNext;
    logic                  recPrev;
    logic                  playPrev;
    logic                  recEdge;
    logic                  playEdge;
    logic [WD_WIDTH-1:0]   wdCnt;
    logic [WD_WIDTH-1:0]   wdCntNext;
    logic                  wdExpire;
    logic                  beginWriteNext;
    logic                  beginReadNext;
    logic [ADDR_WIDTH-1:0] readAddressNext;
    logic [WORD_WIDTH-1:0] playDataNext;
    logic                  playValidNext;
    logic                  bufferValidNext;
    logic                  timeoutErrNext;

    assign recEdge  = recReq & ~recPrev;
    assign playEdge = playReq & ~playPrev;
    assign wdExpire = (TIMEOUT_CYCLES != 0) && (wdCnt == WD_LAST);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and next-output decode; all outputs are registered below.
    always_comb begin
        stateNext       = state;
        wdCntNext       = wdCnt;
        beginWriteNext  = 1'b0;
        beginReadNext   = 1'b0;
        playValidNext   = 1'b0;
        readAddressNext = bram.readAddress;
        playDataNext    = playData;
        bufferValidNext = bufferValid;
        timeoutErrNext  = timeoutErr;

        case (state)
            IDLE: begin
                // Record wins over a simultaneous play edge.
                if (recEdge) begin
                    stateNext       = WR_START;
                    beginWriteNext  = 1'b1;
                    bufferValidNext = 1'b0;
                    timeoutErrNext  = 1'b0;
                end else if (playEdge && bufferValid) begin
                    stateNext       = RD_SETUP;
                    readAddressNext = '0;
                    timeoutErrNext  = 1'b0;
                end
            end
            WR_START: begin
                stateNext = WR_WAIT;
                wdCntNext = '0;
            end
            WR_WAIT: begin
                if (bram.writeComplete) begin
                    stateNext       = IDLE;
                    bufferValidNext = 1'b1;
                end else if (wdExpire) begin
                    stateNext      = IDLE;
                    timeoutErrNext = 1'b1;
                end else if (TIMEOUT_CYCLES != 0) begin
                    wdCntNext = wdCnt + WD_WIDTH'(1);
                end
            end
            RD_SETUP: begin
                stateNext     = RD_START;
                beginReadNext = 1'b1;
            end
            RD_START: begin
                stateNext = RD_WAIT;
                wdCntNext = '0;
            end
            RD_WAIT: begin
                if (bram.readReady) begin
                    stateNext     = RD_NEXT;
                    playDataNext  = bram.outData;
                    playValidNext = 1'b1;
                end else if (wdExpire) begin
                    stateNext      = IDLE;
                    timeoutErrNext = 1'b1;
                end else if (TIMEOUT_CYCLES != 0) begin
                    wdCntNext = wdCnt + WD_WIDTH'(1);
                end
            end
            RD_NEXT: begin
`ifdef LOOP_PLAYBACK_EN
                // Address wraps naturally at the buffer end; only stopReq ends playback.
                if (stopReq) begin
                    stateNext = IDLE;
                end else begin
                    stateNext       = RD_SETUP;
                    readAddressNext = bram.readAddress + ADDR_WIDTH'(1);
                end
`else
                if (stopReq || (bram.readAddress == ADDR_LAST)) begin
                    stateNext = IDLE;
                end else begin
                    stateNext       = RD_SETUP;
                    readAddressNext = bram.readAddress + ADDR_WIDTH'(1);
                end
`endif
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Output, watchdog and request-history registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            recPrev          <= 1'b0;
            playPrev         <= 1'b0;
            wdCnt            <= '0;
            bram.beginWrite  <= 1'b0;
            bram.beginRead   <= 1'b0;
            bram.readAddress <= '0;
            playData         <= '0;
            playValid        <= 1'b0;
            busy             <= 1'b0;
            bufferValid      <= 1'b0;
            timeoutErr       <= 1'b0;
        end else begin
            recPrev          <= recReq;
            playPrev         <= playReq;
            wdCnt            <= wdCntNext;
            bram.beginWrite  <= beginWriteNext;
            bram.beginRead   <= beginReadNext;
            bram.readAddress <= readAddressNext;
            playData         <= playDataNext;
            playValid        <= playValidNext;
            busy             <= (stateNext != IDLE);
            bufferValid      <= bufferValidNext;
            timeoutErr       <= timeoutErrNext;
        end
    end

endmodule

// File: tb/tb_bram_capture_sequencer.sv
// tb_bram_capture_sequencer: randomized bench with a bramController responder
// and a buffer-level reference of what a capture/playback should produce.
module tb_bram_capture_sequencer;

    localparam int unsigned WORD_WIDTH     = 24;
    localparam int unsigned ADDR_WIDTH     = 3;
    localparam int unsigned TIMEOUT_CYCLES = 16;
    localparam int          DEPTH          = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  recReq;
    logic                  playReq;
    logic                  stopReq;
    logic [WORD_WIDTH-1:0] playData;
    logic                  playValid;
    logic                  busy;
    logic                  bufferValid;
    logic                  timeoutErr;

    bram_capture_sequencer_if #(.WORD_WIDTH(WORD_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bram ();

    bram_capture_sequencer #(
        .WORD_WIDTH    (WORD_WIDTH),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bram       (bram.master),
        .recReq     (recReq),
        .playReq    (playReq),
        .stopReq    (stopReq),
        .playData   (playData),
        .playValid  (playValid),
        .busy       (busy),
        .bufferValid(bufferValid),
        .timeoutErr (timeoutErr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Controller model state and observation logs.
    logic [WORD_WIDTH-1:0] mem [DEPTH];
    bit                    wrMute    = 1'b0;
    int                    rdStallAt = 1000;
    int                    rdLatMax  = 2;
    bit                    wrPend    = 1'b0;
    bit                    rdPend    = 1'b0;
    int                    wrDelay;
    int                    rdDelay;
    int                    rdAddr;
    int                    readLog[$];
    logic [WORD_WIDTH-1:0] validLog[$];
    int                    beginWriteCount = 0;
    int                    beginReadCount  = 0;
    int                    lastWriteCycle  = 0;
    int                    lastReadCycle   = 0;
    int                    wcCycle         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // bramController stand-in: answers strobes after a random latency and logs DUT activity.
    always @(negedge clk) begin
        bram.writeComplete = 1'b0;
        bram.readReady     = 1'b0;
        if (reset) begin
            wrPend = 1'b0;
            rdPend = 1'b0;
        end else begin
            if (wrPend) begin
                if (wrDelay == 0) begin
                    bram.writeComplete = 1'b1;
                    wcCycle = cyc;
                    wrPend  = 1'b0;
                end else begin
                    wrDelay--;
                end
            end
            if (rdPend) begin
                if (rdDelay == 0) begin
                    bram.readReady = 1'b1;
                    bram.outData   = mem[rdAddr];
                    rdPend = 1'b0;
                end else begin
                    rdDelay--;
                end
            end
            if (bram.beginWrite) begin
                beginWriteCount++;
                lastWriteCycle = cyc;
                if (!wrMute) begin
                    wrPend  = 1'b1;
                    wrDelay = $urandom_range(0, 5);
                end
            end
            if (bram.beginRead) begin
                beginReadCount++;
                lastReadCycle = cyc;
                readLog.push_back(int'(bram.readAddress));
                if (readLog.size() <= rdStallAt) begin
                    rdPend  = 1'b1;
                    rdAddr  = int'(bram.readAddress);
                    rdDelay = $urandom_range(0, rdLatMax);
                end
            end
            if (playValid) validLog.push_back(playData);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clearLogs();
        readLog.delete();
        validLog.delete();
        beginWriteCount = 0;
        beginReadCount  = 0;
    endtask

    task automatic waitIdle(input int bound, output bit timedOut, output int doneCyc);
        timedOut = 1'b1;
        doneCyc  = -1;
        for (int i = 0; i < bound; i++) begin
            step(1);
            if (!busy) begin
                timedOut = 1'b0;
                doneCyc  = cyc;
                break;
            end
        end
    endtask

    task automatic doCapture();
        bit to;
        int dc;
        recReq = 1'b1;
        step(1);
        recReq = 1'b0;
        waitIdle(40, to, dc);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL capture_done: busy still %0b, required 0 within 40 cycles", busy);
        end
    endtask

    task automatic fillMem(input bit randomData);
        for (int i = 0; i < DEPTH; i++)
            mem[i] = randomData ? WORD_WIDTH'($urandom) : WORD_WIDTH'(10 + i);
    endtask

    // Expected: one beginRead per address in order, one strobe per word carrying mem[addr].
    task automatic checkWords(input string tag, input int nWords);
        checks++;
        if (readLog.size() != nWords || validLog.size() != nWords) begin
            errors++;
            $display("FAIL %s_count: reads %0d strobes %0d, required %0d", tag, readLog.size(), validLog.size(), nWords);
        end else begin
            for (int i = 0; i < nWords; i++) begin
                checks++;
                if (readLog[i] !== i || validLog[i] !== mem[i]) begin
                    errors++;
                    $display("FAIL %s_word%0d: addr %0d data %h, required addr %0d data %h", tag, i, readLog[i], validLog[i], i, mem[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; recReq = 1'b0; playReq = 1'b0; stopReq = 1'b0;
        step(2);
        checks++;
        if ({bram.beginWrite, bram.beginRead, bram.readAddress, playData, playValid, busy, bufferValid, timeoutErr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {bram.beginWrite, bram.beginRead, bram.readAddress, playData, playValid, busy, bufferValid, timeoutErr});
        end
        reset = 1'b0;
        step(2);
        checks++;
        if (busy !== 1'b0 || bufferValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy %0b bufferValid %0b, required 0 0", busy, bufferValid);
        end
    endtask

    task automatic test_guard();
        bit sawBusy = 1'b0;
        clearLogs();
        playReq = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (busy) sawBusy = 1'b1;
        end
        playReq = 1'b0;
        step(2);
        checks++;
        if (beginReadCount != 0 || sawBusy) begin
            errors++;
            $display("FAIL play_guard: beginRead %0d busySeen %0b, required 0 0", beginReadCount, sawBusy);
        end
    endtask

    task automatic test_record();
        bit done = 1'b0;
        int doneCyc = -1;
        bit to;
        clearLogs();
        recReq = 1'b1;
        step(1);
        checks++;
        if (bram.beginWrite !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL record_pulse: beginWrite %0b busy %0b, required 1 1", bram.beginWrite, busy);
        end
        for (int i = 1; i < 10; i++) begin
            step(1);
            if (!done && !busy) begin
                done = 1'b1;
                doneCyc = cyc;
            end
        end
        recReq = 1'b0;
        if (!done) begin
            waitIdle(40, to, doneCyc);
            done = !to;
        end
        checks++;
        if (!done || doneCyc != wcCycle + 1) begin
            errors++;
            $display("FAIL record_done_cycle: cycle %0d, required %0d", doneCyc, wcCycle + 1);
        end
        checks++;
        if (beginWriteCount != 1) begin
            errors++;
            $display("FAIL record_single: beginWrite pulses %0d, required 1", beginWriteCount);
        end
        checks++;
        if (bufferValid !== 1'b1 || timeoutErr !== 1'b0) begin
            errors++;
            $display("FAIL record_flags: bufferValid %0b timeoutErr %0b, required 1 0", bufferValid, timeoutErr);
        end
    endtask

    task automatic test_playback(input bit randomData);
        bit to;
        int dc;
        fillMem(randomData);
        rdLatMax = randomData ? 4 : 1;
        doCapture();
        clearLogs();
        playReq = 1'b1;
        step(1);
        playReq = 1'b0;
        waitIdle(200, to, dc);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL playback_end: busy %0b, required 0 within 200 cycles", busy);
        end
        checkWords(randomData ? "playback_rand" : "playback_seq", DEPTH);
        checks++;
        if (int'(bram.readAddress) != DEPTH - 1 || bufferValid !== 1'b1) begin
            errors++;
            $display("FAIL playback_final: readAddress %0d bufferValid %0b, required %0d 1", bram.readAddress, bufferValid, DEPTH - 1);
        end
    endtask

    task automatic test_priority();
        bit to;
        int dc;
        clearLogs();
        recReq  = 1'b1;
        playReq = 1'b1;
        step(1);
        recReq  = 1'b0;
        playReq = 1'b0;
        checks++;
        if (bram.beginWrite !== 1'b1) begin
            errors++;
            $display("FAIL priority_write: beginWrite %0b, required 1", bram.beginWrite);
        end
        waitIdle(40, to, dc);
        step(3);
        checks++;
        if (to || beginReadCount != 0 || beginWriteCount != 1 || bufferValid !== 1'b1) begin
            errors++;
            $display("FAIL priority_result: beginRead %0d beginWrite %0d bufferValid %0b, required 0 1 1",
                     beginReadCount, beginWriteCount, bufferValid);
        end
    endtask

    task automatic test_abort(input int k);
        bit to;
        int dc;
        bit reached = 1'b0;
        fillMem(1'b1);
        rdLatMax = 3;
        clearLogs();
        playReq = 1'b1;
        step(1);
        playReq = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (readLog.size() == k + 1) begin
                reached = 1'b1;
                break;
            end
            step(1);
        end
        stopReq = 1'b1;
        waitIdle(60, to, dc);
        stopReq = 1'b0;
        step(4);
        checks++;
        if (!reached || to) begin
            errors++;
            $display("FAIL abort%0d_progress: reached %0b timedOut %0b, required 1 0", k, reached, to);
        end
        checkWords("abort", k + 1);
        checks++;
        if (int'(bram.readAddress) != k || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort%0d_final: readAddress %0d busy %0b, required %0d 0", k, bram.readAddress, busy, k);
        end
    endtask

    task automatic test_watchdog();
        bit to;
        int dc;
        int startCyc;
        // Write side never answers.
        wrMute = 1'b1;
        clearLogs();
        recReq = 1'b1;
        step(1);
        recReq = 1'b0;
        startCyc = lastWriteCycle;
        waitIdle(60, to, dc);
        checks++;
        if (to || dc != startCyc + 1 + int'(TIMEOUT_CYCLES)) begin
            errors++;
            $display("FAIL wr_timeout_cycle: idle at %0d, required %0d", dc, startCyc + 1 + int'(TIMEOUT_CYCLES));
        end
        checks++;
        if (timeoutErr !== 1'b1 || bufferValid !== 1'b0) begin
            errors++;
            $display("FAIL wr_timeout_flags: timeoutErr %0b bufferValid %0b, required 1 0", timeoutErr, bufferValid);
        end
        wrMute = 1'b0;
        recReq = 1'b1;
        step(1);
        recReq = 1'b0;
        checks++;
        if (bram.beginWrite !== 1'b1 || timeoutErr !== 1'b0) begin
            errors++;
            $display("FAIL wr_timeout_clear: beginWrite %0b timeoutErr %0b, required 1 0", bram.beginWrite, timeoutErr);
        end
        waitIdle(40, to, dc);
        checks++;
        if (to || bufferValid !== 1'b1 || timeoutErr !== 1'b0) begin
            errors++;
            $display("FAIL wr_recover: bufferValid %0b timeoutErr %0b, required 1 0", bufferValid, timeoutErr);
        end
        // Read side answers only the first word.
        fillMem(1'b1);
        rdStallAt = 1;
        clearLogs();
        playReq = 1'b1;
        step(1);
        playReq = 1'b0;
        waitIdle(100, to, dc);
        checks++;
        if (to || dc != lastReadCycle + 1 + int'(TIMEOUT_CYCLES)) begin
            errors++;
            $display("FAIL rd_timeout_cycle: idle at %0d, required %0d", dc, lastReadCycle + 1 + int'(TIMEOUT_CYCLES));
        end
        checks++;
        if (timeoutErr !== 1'b1 || bufferValid !== 1'b1 || validLog.size() != 1 || int'(bram.readAddress) != 1) begin
            errors++;
            $display("FAIL rd_timeout_flags: timeoutErr %0b bufferValid %0b strobes %0d readAddress %0d, required 1 1 1 1",
                     timeoutErr, bufferValid, validLog.size(), bram.readAddress);
        end
        rdStallAt = 1000;
        clearLogs();
        playReq = 1'b1;
        step(1);
        playReq = 1'b0;
        checks++;
        if (timeoutErr !== 1'b0 || bram.readAddress !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rd_timeout_clear: timeoutErr %0b readAddress %0d busy %0b, required 0 0 1", timeoutErr, bram.readAddress, busy);
        end
        waitIdle(200, to, dc);
        checkWords("replay", DEPTH);
    endtask

    task automatic test_reset_midread();
        bit reached = 1'b0;
        fillMem(1'b1);
        rdStallAt = 3;
        clearLogs();
        playReq = 1'b1;
        step(1);
        playReq = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (readLog.size() == 4) begin
                reached = 1'b1;
                break;
            end
            step(1);
        end
        step(3);
        checks++;
        if (!reached || busy !== 1'b1 || validLog.size() != 3) begin
            errors++;
            $display("FAIL midread_stall: reached %0b busy %0b strobes %0d, required 1 1 3", reached, busy, validLog.size());
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bram.beginWrite, bram.beginRead, bram.readAddress, playData, playValid, busy, bufferValid, timeoutErr} !== '0) begin
            errors++;
            $display("FAIL midread_async_reset: got %h, required 0",
                     {bram.beginWrite, bram.beginRead, bram.readAddress, playData, playValid, busy, bufferValid, timeoutErr});
        end
        step(1);
        reset = 1'b0;
        rdStallAt = 1000;
        step(2);
        clearLogs();
        playReq = 1'b1;
        step(5);
        playReq = 1'b0;
        step(2);
        checks++;
        if (busy !== 1'b0 || beginReadCount != 0 || bufferValid !== 1'b0) begin
            errors++;
            $display("FAIL midread_after_reset: busy %0b beginRead %0d bufferValid %0b, required 0 0 0",
                     busy, beginReadCount, bufferValid);
        end
    endtask

    initial begin
        test_reset();
        test_guard();
        test_record();
        test_playback(1'b0);
        test_playback(1'b1);
        test_priority();
        test_abort(2);
        test_abort($urandom_range(0, DEPTH - 2));
        test_watchdog();
        test_reset_midread();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, required completion before 500000");
        $fatal(1);
    end

endmodule
